// File: rtl/div_defs.sv
// Shared widths and FSM encodings for the 128-by-64 restoring divider.
//   DIVIDEND_W : dividend width (128)
//   DIVISOR_W  : divisor, quotient and remainder width (64)
//   CNT_W      : width of the step counter (64 steps)
package div_defs;
  localparam int DIVIDEND_W = 128;
  localparam int DIVISOR_W  = 64;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_128by64_if.sv
// Handshake and data bundle for div_128by64.
//   start, a, b          : request and operands (master -> slave)
//   busy, done           : status (slave -> master)
//   q, r, dbz, ovf       : results and flags (slave -> master)
interface div_128by64_if;
  import div_defs::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] a;
  logic [DIVISOR_W-1:0]  b;
  logic                  busy;
  logic                  done;
  logic [DIVISOR_W-1:0]  q;
  logic [DIVISOR_W-1:0]  r;
  logic                  dbz;
  logic                  ovf;

  modport master (
    output start, a, b,
    input  busy, done, q, r, dbz, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, dbz, ovf
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder and subtracts the divisor when it fits.
//   rem      : current partial remainder (always < divisor)
//   bit_in   : next dividend bit, MSB first
//   divisor  : divisor
//   rem_next : updated partial remainder
//   q_bit    : resolved quotient bit
module div_step
  import div_defs::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_next,
  output logic                 q_bit
);
  // The shifted remainder needs a 65th bit; since rem < divisor beforehand,
  // the result after an optional subtract fits back into 64 bits.
  logic [DIVISOR_W:0] t;
  logic [DIVISOR_W:0] d;

  assign t        = {rem, bit_in};
  assign d        = {1'b0, divisor};
  assign q_bit    = (t >= d);
  assign rem_next = q_bit ? DIVISOR_W'(t - d) : t[DIVISOR_W-1:0];
endmodule

// File: rtl/div_128by64.sv
// Sequential restoring divider, 128-bit dividend / 64-bit divisor.
// One quotient bit per clock; divide-by-zero and quotient overflow resolve
// in a single cycle without entering the iteration.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : div_128by64_if slave (start/a/b in; busy/done/q/r/dbz/ovf out)
//
// state  | meaning
// S_IDLE | waiting for start; results from the last operation held
// S_CALC | resolving one quotient bit per cycle (64 cycles)
// S_DONE | done pulse for one cycle, results valid
module div_128by64
  import div_defs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  div_128by64_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      count;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  sreg;
  logic [DIVISOR_W-1:0]  q_reg;
  logic [DIVISOR_W-1:0]  r_reg;
  logic                  dbz_reg;
  logic                  ovf_reg;

  logic [DIVISOR_W-1:0]  a_hi;
  logic [DIVISOR_W-1:0]  a_lo;
  logic                  accept;
  logic                  is_dbz;
  logic                  is_ovf;
  logic [DIVISOR_W-1:0]  rem_next;
  logic                  q_bit;

  assign a_hi   = bus.a[DIVIDEND_W-1:DIVISOR_W];
  assign a_lo   = bus.a[DIVISOR_W-1:0];
  assign accept = (state == S_IDLE) && bus.start;
  assign is_dbz = (bus.b == '0);
  // Upper half >= divisor means the quotient cannot fit in 64 bits.
  assign is_ovf = !is_dbz && (a_hi >= bus.b);

  div_step u_step (
    .rem      (rem),
    .bit_in   (sreg[DIVISOR_W-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (is_dbz || is_ovf) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (count == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      divisor <= '0;
      rem     <= '0;
      sreg    <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      divisor <= bus.b;
      count   <= '0;
      if (is_dbz) begin
        dbz_reg <= 1'b1;
        ovf_reg <= 1'b0;
        q_reg   <= '1;
        r_reg   <= a_lo;
      end else if (is_ovf) begin
        dbz_reg <= 1'b0;
        ovf_reg <= 1'b1;
        q_reg   <= '1;
        r_reg   <= '0;
      end else begin
        dbz_reg <= 1'b0;
        ovf_reg <= 1'b0;
        q_reg   <= '0;
        r_reg   <= '0;
        rem     <= a_hi;
        sreg    <= a_lo;
      end
    end else if (state == S_CALC) begin
      // Dividend bits leave the top of sreg while quotient bits enter the
      // bottom, so after 64 steps sreg holds the full quotient.
      rem   <= rem_next;
      sreg  <= {sreg[DIVISOR_W-2:0], q_bit};
      count <= count + 1'b1;
      if (count == CNT_LAST) begin
        q_reg <= {sreg[DIVISOR_W-2:0], q_bit};
        r_reg <= rem_next;
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.dbz  = dbz_reg;
  assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_div_128by64.sv
module tb_div_128by64;
  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  div_128by64_if bif();

  div_128by64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic drive_start(input logic [127:0] a, input logic [63:0] b);
    bif.start = 1'b1;
    bif.a     = a;
    bif.b     = b;
    @(negedge clk);
    bif.start = 1'b0;
    bif.a     = {$urandom, $urandom, $urandom, $urandom};
    bif.b     = {$urandom, $urandom};
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int lat0, output int lat, output bit to);
    lat = lat0;
    to  = 1'b0;
    while (bif.done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (bif.done !== 1'b1) to = 1'b1;
  endtask

  task automatic push_exp(input logic [63:0] q, input logic [63:0] r,
                          input logic dbz, input logic ovf, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bif.start = 1'b0;
    bif.a     = '0;
    bif.b     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.busy, bif.done, bif.dbz, bif.ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: busy/done/dbz/ovf=%b required 0000",
               {bif.busy, bif.done, bif.dbz, bif.ovf});
    end
    checks++;
    if ({bif.q, bif.r} !== 128'd0) begin
      errors++;
      $display("FAIL reset_qr: q=%h r=%h required 0", bif.q, bif.r);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pow2;
    exp_t e;
    int lat;
    bit to;
    push_exp(64'h0040_0000_0000_0000, 64'd0, 1'b0, 1'b0, 64);
    drive_start(128'h0100_0000_0000_0000, 64'd4);
    checks++;
    if (bif.busy !== 1'b1 || bif.done !== 1'b0) begin
      errors++;
      $display("FAIL pow2_busy: busy=%b done=%b required busy=1 done=0", bif.busy, bif.done);
    end
    wait_done(0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != e.lat) begin
      errors++;
      $display("FAIL pow2_latency: edges=%0d timeout=%0d required %0d", lat, to, e.lat);
    end
    checks++;
    if ({bif.q, bif.r, bif.dbz, bif.ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
      errors++;
      $display("FAIL pow2_result: q=%h r=%h dbz=%b ovf=%b required q=%h r=%h dbz=%b ovf=%b",
               bif.q, bif.r, bif.dbz, bif.ovf, e.q, e.r, e.dbz, e.ovf);
    end
    @(negedge clk);
    checks++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0 || bif.q !== e.q) begin
      errors++;
      $display("FAIL pow2_after: done=%b busy=%b q=%h required done=0 busy=0 q=%h",
               bif.done, bif.busy, bif.q, e.q);
    end
  endtask

  task automatic test_basic;
    exp_t e;
    int lat;
    bit to;
    logic [127:0] av [2];
    logic [63:0]  bv [2];
    av[0] = 128'd100; bv[0] = 64'd7;
    av[1] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; bv[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    push_exp(64'd14, 64'd2, 1'b0, 1'b0, 64);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 64);
    for (int i = 0; i < 2; i++) begin
      drive_start(av[i], bv[i]);
      wait_done(0, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != e.lat ||
          {bif.q, bif.r, bif.dbz, bif.ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
        errors++;
        $display("FAIL basic_%0d: q=%h r=%h dbz=%b ovf=%b edges=%0d required q=%h r=%h dbz=%b ovf=%b edges=%0d",
                 i, bif.q, bif.r, bif.dbz, bif.ovf, lat, e.q, e.r, e.dbz, e.ovf, e.lat);
      end
      @(negedge clk);
    end
  endtask

  // Exceptions finish in the cycle right after acceptance (0 extra edges).
  task automatic test_exceptions;
    exp_t e;
    int lat;
    bit to;
    logic [127:0] av [3];
    logic [63:0]  bv [3];
    av[0] = 128'h1234;                  bv[0] = 64'd0;
    av[1] = 128'h1_0000_0000_0000_0000; bv[1] = 64'd1;
    av[2] = 128'h1_0000_0000_0000_0000; bv[2] = 64'd2;
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1'b0, 0);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'd0,    1'b0, 1'b1, 0);
    push_exp(64'h8000_0000_0000_0000, 64'd0,    1'b0, 1'b0, 64);
    for (int i = 0; i < 3; i++) begin
      drive_start(av[i], bv[i]);
      wait_done(0, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != e.lat) begin
        errors++;
        $display("FAIL exc_latency_%0d: edges=%0d timeout=%0d required %0d", i, lat, to, e.lat);
      end
      checks++;
      if ({bif.q, bif.r, bif.dbz, bif.ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
        errors++;
        $display("FAIL exc_result_%0d: q=%h r=%h dbz=%b ovf=%b required q=%h r=%h dbz=%b ovf=%b",
                 i, bif.q, bif.r, bif.dbz, bif.ovf, e.q, e.r, e.dbz, e.ovf);
      end
      @(negedge clk);
      checks++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
        errors++;
        $display("FAIL exc_idle_%0d: busy=%b done=%b required 0 0", i, bif.busy, bif.done);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int lat;
    bit to;
    push_exp(64'd14, 64'd2, 1'b0, 1'b0, 64);
    drive_start(128'd100, 64'd7);
    repeat (9) @(negedge clk);
    bif.start = 1'b1;
    bif.a     = 128'd9;
    bif.b     = 64'd3;
    @(negedge clk);
    bif.start = 1'b0;
    wait_done(10, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != e.lat ||
        {bif.q, bif.r, bif.dbz, bif.ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
      errors++;
      $display("FAIL ignore_start: q=%h r=%h edges=%0d required q=%h r=%h edges=%0d",
               bif.q, bif.r, lat, e.q, e.r, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    exp_t e;
    int lat;
    bit to;
    bit saw_done;
    drive_start(128'd100, 64'd7);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.busy, bif.done, bif.dbz, bif.ovf} !== 4'b0000 || {bif.q, bif.r} !== 128'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b dbz=%b ovf=%b q=%h r=%h required all 0",
               bif.busy, bif.done, bif.dbz, bif.ovf, bif.q, bif.r);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bif.done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (bif.done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrun_no_done: done seen=1 required 0");
    end
    push_exp(64'd111, 64'd1, 1'b0, 1'b0, 64);
    drive_start(128'd1000, 64'd9);
    wait_done(0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != e.lat ||
        {bif.q, bif.r, bif.dbz, bif.ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
      errors++;
      $display("FAIL after_reset: q=%h r=%h edges=%0d required q=%h r=%h edges=%0d",
               bif.q, bif.r, lat, e.q, e.r, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    bit to;
    push_exp(64'd14, 64'd2, 1'b0, 1'b0, 64);
    push_exp(64'd111, 64'd1, 1'b0, 1'b0, 64);
    bif.start = 1'b1;
    bif.a     = 128'd100;
    bif.b     = 64'd7;
    @(negedge clk);
    wait_done(0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != e.lat || {bif.q, bif.r} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL b2b_first: q=%h r=%h edges=%0d required q=%h r=%h edges=%0d",
               bif.q, bif.r, lat, e.q, e.r, e.lat);
    end
    bif.a = 128'd1000;
    bif.b = 64'd9;
    @(negedge clk);
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b required 0", bif.busy);
    end
    @(negedge clk);
    bif.start = 1'b0;
    checks++;
    if (bif.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: busy=%b required 1", bif.busy);
    end
    wait_done(0, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != e.lat || {bif.q, bif.r} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL b2b_second: q=%h r=%h edges=%0d required q=%h r=%h edges=%0d",
               bif.q, bif.r, lat, e.q, e.r, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    exp_t e;
    int lat;
    bit to;
    int fails;
    logic [63:0]  x, y, z;
    logic [127:0] a;
    fails = 0;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 4 == 0) y = y >> $urandom_range(63, 0);
      if (y == 64'd0) y = 64'd1;
      z = {$urandom, $urandom};
      z = z % y;
      a = {64'd0, x} * {64'd0, y} + {64'd0, z};
      push_exp(x, z, 1'b0, 1'b0, 64);
      drive_start(a, y);
      wait_done(0, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != e.lat ||
          {bif.q, bif.r, bif.dbz, bif.ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
        errors++;
        if (fails < 10)
          $display("FAIL random_%0d: q=%h r=%h dbz=%b ovf=%b edges=%0d required q=%h r=%h flags 0 edges=%0d",
                   i, bif.q, bif.r, bif.dbz, bif.ovf, lat, e.q, e.r, e.lat);
        fails++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    bif.start = 1'b0;
    bif.a     = '0;
    bif.b     = '0;
    test_reset();
    test_pow2();
    test_basic();
    test_exceptions();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
